// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU_OP codes and datapath mux selects.
package rv32_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECR    = 4'd7,
        S_EXECI    = 4'd8,
        S_ALUWB    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JAL      = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Opcode dispatch out of DECODE; anything unrecognised traps.
    function automatic state_t decode_next(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_STORE: decode_next = S_MEMADR;
            OP_RTYPE:          decode_next = S_EXECR;
            OP_ITYPE:          decode_next = S_EXECI;
            OP_BRANCH:         decode_next = S_BRANCH;
            OP_JAL:            decode_next = S_JAL;
            default:           decode_next = S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch decision from funct3 and the registered ALU flags (BEQ/BNE/BLT only).
module branch_resolve
    import rv32_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control sequencer: steps FETCH..WRITEBACK over a
// shared ALU and unified memory port with a variable-latency handshake.
module multicycle_control_fsm
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned RESET_PC_HOLD = 1,
    parameter int unsigned TRAP_STICKY   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] ALU_OP,
    output logic       illegal_instr,
    output logic [3:0] state_dbg
);

    state_t     state_reg, state_next;
    logic [3:0] hold_reg, hold_next;
    logic       taken;

    branch_resolve u_branch_resolve (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .taken  (taken)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            hold_reg  <= 4'(RESET_PC_HOLD);
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_next     = hold_reg;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        ALU_OP        = ALUOP_ADD;
        illegal_instr = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // Leaving on the decrement that reaches zero gives exactly
                // RESET_PC_HOLD cycles between reset release and FETCH.
                hold_next = hold_reg - 4'd1;
                if (hold_reg <= 4'd1) state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                state_next = decode_next(op);
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                ALU_OP     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                ALU_OP     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                ALU_OP     = ALUOP_BRANCH;
                pc_write   = taken;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // Target was precomputed in DECODE; the ALU now forms the link.
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                if (TRAP_STICKY == 0) state_next = S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign state_dbg = state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: a per-instruction expected state path and
// per-state control word model are compared cycle by cycle against the DUT.
module tb_multicycle_control_fsm;

    typedef struct {
        int   st;
        logic rdy;
    } step_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       illegal_instr;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.RESET_PC_HOLD(3), .TRAP_STICKY(1)) dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .funct3        (funct3),
        .zero          (zero),
        .lt            (lt),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .result_src    (result_src),
        .ALU_OP        (alu_op),
        .illegal_instr (illegal_instr),
        .state_dbg     (state_dbg)
    );

    // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
    //  alu_src_a, alu_src_b, result_src, alu_op, illegal_instr}
    function automatic logic [14:0] outs_now();
        return {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_op, illegal_instr};
    endfunction

    function automatic logic [14:0] exp_outs(input int st, input logic rdy, input logic tk);
        logic req = 0, wr = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
        logic [1:0] a = 0, b = 0, res = 0, aop = 0;
        case (st)
            1:  begin req = 1; b = 2; res = 2; irw = rdy; pcw = rdy; end
            2:  begin a = 1; b = 1; end
            3:  begin a = 2; b = 1; end
            4:  begin req = 1; adr = 1; end
            5:  begin res = 1; rw = 1; end
            6:  begin req = 1; wr = 1; adr = 1; end
            7:  begin a = 2; b = 0; aop = 2; end
            8:  begin a = 2; b = 1; aop = 2; end
            9:  begin rw = 1; end
            10: begin a = 2; b = 0; aop = 1; pcw = tk; end
            11: begin a = 1; b = 2; pcw = 1; rw = 1; end
            12: begin ill = 1; end
            default: ;
        endcase
        return {req, wr, adr, irw, pcw, rw, a, b, res, aop, ill};
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic l);
        if (f3 == 3'd0) return z;
        if (f3 == 3'd1) return !z;
        if (f3 == 3'd4) return l;
        return 1'b0;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Every step starts 1 time unit after a rising edge.
    task automatic apply_reset(input string name);
        rst = 1'b0;
        mem_ready = 1'b1;
        op = 7'($urandom);
        #2;
        n_checks++;
        if (state_dbg !== 4'd0 || outs_now() !== 15'd0) begin
            n_fails++;
            $display("FAIL %s in_reset: got state=%0d outs=%h expected state=0 outs=0000", name, state_dbg, outs_now());
        end
        @(posedge clk); #1;
        n_checks++;
        if (state_dbg !== 4'd0 || outs_now() !== 15'd0) begin
            n_fails++;
            $display("FAIL %s held_reset: got state=%0d outs=%h expected state=0 outs=0000", name, state_dbg, outs_now());
        end
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (state_dbg !== ((k < 3) ? 4'd0 : 4'd1)) begin
                n_fails++;
                $display("FAIL %s hold_cycle%0d: got state=%0d expected %0d", name, k, state_dbg, (k < 3) ? 0 : 1);
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic z,
                             input logic l, input int fw, input int mw, input string name);
        step_t q[$];
        logic  tk;
        tk = branch_taken(f3, z, l);
        repeat (fw) q.push_back('{1, 1'b0});
        q.push_back('{1, 1'b1});
        q.push_back('{2, rbit()});
        case (o)
            7'b0000011: begin
                q.push_back('{3, rbit()});
                repeat (mw) q.push_back('{4, 1'b0});
                q.push_back('{4, 1'b1});
                q.push_back('{5, rbit()});
            end
            7'b0100011: begin
                q.push_back('{3, rbit()});
                repeat (mw) q.push_back('{6, 1'b0});
                q.push_back('{6, 1'b1});
            end
            7'b0110011: begin q.push_back('{7, rbit()}); q.push_back('{9, rbit()}); end
            7'b0010011: begin q.push_back('{8, rbit()}); q.push_back('{9, rbit()}); end
            7'b1100011: q.push_back('{10, rbit()});
            7'b1101111: q.push_back('{11, rbit()});
            default:    q.push_back('{12, rbit()});
        endcase
        op = o; funct3 = f3; zero = z; lt = l;
        for (int i = 0; i < q.size(); i++) begin
            mem_ready = q[i].rdy;
            #2;
            n_checks++;
            if (state_dbg !== 4'(q[i].st)) begin
                n_fails++;
                $display("FAIL %s step%0d state: got %0d expected %0d", name, i, state_dbg, q[i].st);
            end
            n_checks++;
            if (outs_now() !== exp_outs(q[i].st, q[i].rdy, tk)) begin
                n_fails++;
                $display("FAIL %s step%0d outs: got %h expected %h (state %0d)", name, i,
                         outs_now(), exp_outs(q[i].st, q[i].rdy, tk), q[i].st);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

    task automatic test_rtype();
        logic [31:0] instr = 32'h002081B3;
        run_instr(instr[6:0], instr[14:12], 1'b0, 1'b0, 0, 0, "rtype_add");
    endtask

    task automatic test_load_wait();
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, "load_wait");
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 2, "store_wait");
    endtask

    task automatic test_branch();
        run_instr(7'b1100011, 3'b000, 1'b1, 1'b0, 0, 0, "beq_taken");
        run_instr(7'b1100011, 3'b001, 1'b1, 1'b0, 0, 0, "bne_not_taken");
        run_instr(7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0, "blt_taken");
        run_instr(7'b1100011, 3'b110, 1'b1, 1'b1, 0, 0, "bltu_never");
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, "jal");
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        for (int n = 0; n < 60; n++)
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom), rbit(), rbit(),
                      $urandom_range(0, 2), $urandom_range(0, 3), "random");
    endtask

    task automatic test_trap();
        run_instr(7'h7F, 3'd0, 1'b0, 1'b0, 0, 0, "trap_entry");
        for (int k = 0; k < 5; k++) begin
            mem_ready = rbit();
            op = 7'b0110011;
            #2;
            n_checks++;
            if (state_dbg !== 4'd12 || outs_now() !== exp_outs(12, 1'b0, 1'b0)) begin
                n_fails++;
                $display("FAIL trap_sticky%0d: got state=%0d outs=%h expected state=12 outs=%h",
                         k, state_dbg, outs_now(), exp_outs(12, 1'b0, 1'b0));
            end
            @(posedge clk); #1;
        end
        apply_reset("trap_clear");
    endtask

    task automatic test_fetch_reset();
        mem_ready = 1'b0;
        #2;
        n_checks++;
        if (state_dbg !== 4'd1 || mem_req !== 1'b1 || ir_write !== 1'b0) begin
            n_fails++;
            $display("FAIL fetch_stall: got state=%0d mem_req=%b ir_write=%b expected 1 1 0",
                     state_dbg, mem_req, ir_write);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== 4'd0 || mem_req !== 1'b0 || ir_write !== 1'b0 || pc_write !== 1'b0) begin
            n_fails++;
            $display("FAIL fetch_async_drop: got state=%0d mem_req=%b ir=%b pc=%b expected 0 0 0 0",
                     state_dbg, mem_req, ir_write, pc_write);
        end
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (outs_now() !== 15'd0) begin
                n_fails++;
                $display("FAIL fetch_reset_hold%0d: got outs=%h expected 0000", k, outs_now());
            end
        end
        apply_reset("fetch_reset");
        run_instr(7'b0010011, 3'd0, 1'b0, 1'b0, 0, 0, "after_reset_itype");
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_rtype();
        test_load_wait();
        test_branch();
        test_random();
        test_trap();
        test_fetch_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
